multicycle_controller: RTL and testbench

Parametrised successor to the fixed-sequence multicycle control unit. Drives every datapath select and write enable of the 32-bit MIPS multicycle core, adds a valid/ready handshake with variable-latency instruction/data memory, supports BNE and J, and reports illegal opcodes and memory timeouts through a sticky fault state. It sits beside the datapath, decoding the latched instruction fields and the ALU zero flag.

---
 rtl/multicycle_controller_pkg.sv | 31 +++
 rtl/multicycle_controller_if.sv | 8 +
 rtl/multicycle_controller_alu_decoder.sv | 25 ++
 rtl/multicycle_controller.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared states, opcodes, function codes and select encodings (package mc_ctrl_pkg)
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_FAULT
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALU_REG = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction/data memory valid/ready handshake
interface multicycle_controller_if;
  logic mem_req;
  logic mem_wr_en;
  logic mem_ready;
  modport master (output mem_req, output mem_wr_en, input mem_ready);
  modport slave (input mem_req, input mem_wr_en, output mem_ready);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// mc_alu_decoder: R-type function code to ALU control, with legality flag
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_WIDTH_P = 6,
  parameter int ALU_CNTRL_WIDTH_P = 3
) (
  input  logic [FUNCT_WIDTH_P-1:0]     funct,
  output logic [ALU_CNTRL_WIDTH_P-1:0] alu_cntrl,
  output logic                         legal
);
  localparam logic [FUNCT_WIDTH_P-1:0] F_ADD = FUNCT_WIDTH_P'(FN_ADD);
  localparam logic [FUNCT_WIDTH_P-1:0] F_SUB = FUNCT_WIDTH_P'(FN_SUB);
  localparam logic [FUNCT_WIDTH_P-1:0] F_AND = FUNCT_WIDTH_P'(FN_AND);
  localparam logic [FUNCT_WIDTH_P-1:0] F_OR  = FUNCT_WIDTH_P'(FN_OR);
  localparam logic [FUNCT_WIDTH_P-1:0] F_SLT = FUNCT_WIDTH_P'(FN_SLT);
  always_comb begin
    alu_cntrl = funct == F_SUB ? ALU_CNTRL_WIDTH_P'(ALU_SUB) :
                funct == F_AND ? ALU_CNTRL_WIDTH_P'(ALU_AND) :
                funct == F_OR  ? ALU_CNTRL_WIDTH_P'(ALU_OR)  :
                funct == F_SLT ? ALU_CNTRL_WIDTH_P'(ALU_SLT) :
                                 ALU_CNTRL_WIDTH_P'(ALU_ADD);
    legal = funct == F_ADD || funct == F_SUB || funct == F_AND || funct == F_OR || funct == F_SLT;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: MIPS multicycle control FSM with memory handshake and sticky fault.
// Define MC_PERF_COUNTERS_EN to add cycle and retired-instruction counters.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CNTRL_WIDTH_P = 3,
  parameter int OP_WIDTH_P = 6,
  parameter int FUNCT_WIDTH_P = 6,
  parameter int MEM_TIMEOUT_P = 16,
  parameter int PERF_WIDTH_P = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_enable,
  input  logic [OP_WIDTH_P-1:0]        i_opcode,
  input  logic [FUNCT_WIDTH_P-1:0]     i_function,
  input  logic                         i_zero,
  multicycle_controller_if.master      mem,
  output logic                         o_instr_data_addr_sel,
  output logic                         o_instr_wr_en,
  output logic                         o_pc_wr_en,
  output logic                         o_branch,
  output logic                         o_branch_ne,
  output logic [1:0]                   o_pc_next_sel,
  output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
  output logic                         o_alu_src_a_sel,
  output logic [1:0]                   o_alu_src_b_sel,
  output logic                         o_reg_wr_en,
  output logic                         o_reg_wr_addr_sel,
  output logic                         o_reg_wr_data_sel,
  output logic [3:0]                   o_state,
  output logic                         o_fault
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [PERF_WIDTH_P-1:0]      o_cycle_cnt,
  output logic [PERF_WIDTH_P-1:0]      o_instret_cnt
`endif
);
  localparam int CW = MEM_TIMEOUT_P > 1 ? $clog2(MEM_TIMEOUT_P) : 1;
  state_t state, next;
  logic [CW-1:0] wait_cnt;
  logic req_wait, timeout;
  logic is_lw, is_sw, is_rtype, is_beq, is_bne, is_addi, is_j;
  logic [ALU_CNTRL_WIDTH_P-1:0] fn_alu;
  logic fn_legal;
  // branch resolution against i_zero happens in the datapath
  logic unused_zero;
  assign unused_zero = i_zero;
  assign is_lw    = i_opcode == OP_WIDTH_P'(OP_LW);
  assign is_sw    = i_opcode == OP_WIDTH_P'(OP_SW);
  assign is_rtype = i_opcode == OP_WIDTH_P'(OP_RTYPE);
  assign is_beq   = i_opcode == OP_WIDTH_P'(OP_BEQ);
  assign is_bne   = i_opcode == OP_WIDTH_P'(OP_BNE);
  assign is_addi  = i_opcode == OP_WIDTH_P'(OP_ADDI);
  assign is_j     = i_opcode == OP_WIDTH_P'(OP_J);
  assign req_wait = (state == S_FETCH || state == S_MEMRD || state == S_MEMWR) && !mem.mem_ready;
  // the cycle that would complete the MEM_TIMEOUT_P-th consecutive wait faults
  assign timeout = MEM_TIMEOUT_P != 0 && req_wait && wait_cnt == CW'(MEM_TIMEOUT_P - 1);
  assign o_state = state;
  assign o_fault = state == S_FAULT;
  mc_alu_decoder #(.FUNCT_WIDTH_P(FUNCT_WIDTH_P), .ALU_CNTRL_WIDTH_P(ALU_CNTRL_WIDTH_P)) u_alu_dec (
    .funct(i_function),
    .alu_cntrl(fn_alu),
    .legal(fn_legal)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next;
      wait_cnt <= (next == state && req_wait) ? wait_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    next = state;
    mem.mem_req = 1'b0;
    mem.mem_wr_en = 1'b0;
    o_instr_data_addr_sel = 1'b0;
    o_instr_wr_en = 1'b0;
    o_pc_wr_en = 1'b0;
    o_branch = 1'b0;
    o_branch_ne = 1'b0;
    o_pc_next_sel = PC_ALU;
    o_alu_cntrl = '0;
    o_alu_src_a_sel = 1'b0;
    o_alu_src_b_sel = SRCB_REG;
    o_reg_wr_en = 1'b0;
    o_reg_wr_addr_sel = 1'b0;
    o_reg_wr_data_sel = 1'b0;
    case (state)
      S_IDLE: next = i_enable ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        o_alu_src_b_sel = SRCB_FOUR;
        o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
        o_instr_wr_en = mem.mem_ready;
        o_pc_wr_en = mem.mem_ready;
        next = mem.mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        o_alu_src_b_sel = SRCB_IMM_SH;
        o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
        next = (is_lw || is_sw) ? S_MEMADR : is_rtype ? S_EXEC : (is_beq || is_bne) ? S_BRANCH :
               is_addi ? S_ADDIEX : is_j ? S_JUMP : S_FAULT;
      end
      S_MEMADR: begin
        o_alu_src_a_sel = 1'b1;
        o_alu_src_b_sel = SRCB_IMM;
        o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
        next = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem.mem_req = 1'b1;
        o_instr_data_addr_sel = 1'b1;
        next = mem.mem_ready ? S_MEMWB : timeout ? S_FAULT : S_MEMRD;
      end
      S_MEMWB: begin
        o_reg_wr_en = 1'b1;
        o_reg_wr_data_sel = 1'b1;
        next = i_enable ? S_FETCH : S_IDLE;
      end
      S_MEMWR: begin
        mem.mem_req = 1'b1;
        mem.mem_wr_en = 1'b1;
        o_instr_data_addr_sel = 1'b1;
        next = mem.mem_ready ? (i_enable ? S_FETCH : S_IDLE) : timeout ? S_FAULT : S_MEMWR;
      end
      S_EXEC: begin
        o_alu_src_a_sel = 1'b1;
        o_alu_cntrl = fn_alu;
        next = fn_legal ? S_ALUWB : S_FAULT;
      end
      S_ALUWB: begin
        o_reg_wr_en = 1'b1;
        o_reg_wr_addr_sel = 1'b1;
        next = i_enable ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        o_alu_src_a_sel = 1'b1;
        o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_SUB);
        o_pc_next_sel = PC_ALU_REG;
        o_branch = is_beq;
        o_branch_ne = is_bne;
        next = i_enable ? S_FETCH : S_IDLE;
      end
      S_ADDIEX: begin
        o_alu_src_a_sel = 1'b1;
        o_alu_src_b_sel = SRCB_IMM;
        o_alu_cntrl = ALU_CNTRL_WIDTH_P'(ALU_ADD);
        next = S_ADDIWB;
      end
      S_ADDIWB: begin
        o_reg_wr_en = 1'b1;
        next = i_enable ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        o_pc_wr_en = 1'b1;
        o_pc_next_sel = PC_JUMP;
        next = i_enable ? S_FETCH : S_IDLE;
      end
      S_FAULT: next = S_FAULT;
      default: next = S_IDLE;
    endcase
  end
`ifdef MC_PERF_COUNTERS_EN
  // an instruction retires when a completing state hands over to FETCH or IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cycle_cnt <= '0;
      o_instret_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_FAULT) o_cycle_cnt <= o_cycle_cnt + 1'b1;
      if (state != S_IDLE && state != S_FETCH && (next == S_FETCH || next == S_IDLE)) o_instret_cnt <= o_instret_cnt + 1'b1;
    end
  end
`else
  localparam int unused_perf_w = PERF_WIDTH_P;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams expanded into expected per-cycle traces
module tb_multicycle_controller;
  import mc_ctrl_pkg::*;
  localparam int TO = 16;
  typedef struct packed {
    logic req, wr, adr, iwr, pcwr, br, bne;
    logic [1:0] pcn;
    logic [2:0] alu;
    logic sa;
    logic [1:0] sb;
    logic rwr, rda, rdd;
  } ctrl_t;
  typedef struct {
    state_t st;
    ctrl_t c;
    bit rdy, en, chk, ret;
    logic [5:0] op, fn;
  } rec_t;
  logic clk = 0, reset = 0, i_enable = 0, i_zero = 0;
  logic [5:0] i_opcode = 0, i_function = 0;
  logic o_instr_data_addr_sel, o_instr_wr_en, o_pc_wr_en, o_branch, o_branch_ne;
  logic [1:0] o_pc_next_sel, o_alu_src_b_sel;
  logic [2:0] o_alu_cntrl;
  logic o_alu_src_a_sel, o_reg_wr_en, o_reg_wr_addr_sel, o_reg_wr_data_sel, o_fault;
  logic [3:0] o_state;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] o_cycle_cnt, o_instret_cnt;
`endif
  ctrl_t got;
  rec_t q[$];
  int n_chk = 0, n_fail = 0, m_cyc = 0, m_ret = 0;
  logic [5:0] cur_op = 0, cur_fn = 0;
  bit dead = 0;
  logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
  logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  multicycle_controller_if mem();
  multicycle_controller dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_opcode(i_opcode), .i_function(i_function),
    .i_zero(i_zero), .mem(mem), .o_instr_data_addr_sel(o_instr_data_addr_sel),
    .o_instr_wr_en(o_instr_wr_en), .o_pc_wr_en(o_pc_wr_en), .o_branch(o_branch),
    .o_branch_ne(o_branch_ne), .o_pc_next_sel(o_pc_next_sel), .o_alu_cntrl(o_alu_cntrl),
    .o_alu_src_a_sel(o_alu_src_a_sel), .o_alu_src_b_sel(o_alu_src_b_sel), .o_reg_wr_en(o_reg_wr_en),
    .o_reg_wr_addr_sel(o_reg_wr_addr_sel), .o_reg_wr_data_sel(o_reg_wr_data_sel),
    .o_state(o_state), .o_fault(o_fault)
`ifdef MC_PERF_COUNTERS_EN
    , .o_cycle_cnt(o_cycle_cnt), .o_instret_cnt(o_instret_cnt)
`endif
  );
  assign got = {mem.mem_req, mem.mem_wr_en, o_instr_data_addr_sel, o_instr_wr_en, o_pc_wr_en, o_branch,
                o_branch_ne, o_pc_next_sel, o_alu_cntrl, o_alu_src_a_sel, o_alu_src_b_sel,
                o_reg_wr_en, o_reg_wr_addr_sel, o_reg_wr_data_sel};
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask
  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic ctrl_t alu_c(bit sa, logic [1:0] sb, logic [2:0] alu);
    ctrl_t c = '0;
    c.sa = sa; c.sb = sb; c.alu = alu;
    return c;
  endfunction
  function automatic ctrl_t wb_c(bit rd, bit md);
    ctrl_t c = '0;
    c.rwr = 1; c.rda = rd; c.rdd = md;
    return c;
  endfunction
  function automatic logic [3:0] alu_of(logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction
  task automatic push(state_t s, ctrl_t c, bit rdy, bit en, bit ret = 0, bit chk = 1);
    rec_t r;
    r.st = s; r.c = c; r.rdy = rdy; r.en = en; r.ret = ret; r.chk = chk; r.op = cur_op; r.fn = cur_fn;
    q.push_back(r);
  endtask
  task automatic fault_tail();
    repeat (3) push(S_FAULT, '0, rb(), rb());
    dead = 1;
  endtask
  // w consecutive not-ready cycles; the TO-th one ends in FAULT
  task automatic mem_wait(state_t s, ctrl_t c, int w);
    for (int i = 0; i < w && i < TO; i++) push(s, c, 0, rb());
    if (w >= TO) fault_tail();
  endtask
  task automatic gen_instr(logic [5:0] op, logic [5:0] fn, int wf, int wm, bit en_end);
    ctrl_t c;
    logic [3:0] af;
    cur_op = op; cur_fn = fn;
    c = alu_c(0, 2'b01, 3'b010); c.req = 1;
    mem_wait(S_FETCH, c, wf);
    if (dead) return;
    c.iwr = 1; c.pcwr = 1;
    push(S_FETCH, c, 1, rb());
    push(S_DECODE, alu_c(0, 2'b11, 3'b010), rb(), rb());
    case (op)
      6'b100011, 6'b101011: begin
        push(S_MEMADR, alu_c(1, 2'b10, 3'b010), rb(), rb());
        c = '0; c.req = 1; c.adr = 1; c.wr = op == 6'b101011;
        mem_wait(op == 6'b100011 ? S_MEMRD : S_MEMWR, c, wm);
        if (dead) return;
        if (op == 6'b100011) begin
          push(S_MEMRD, c, 1, rb());
          push(S_MEMWB, wb_c(0, 1), rb(), en_end, 1);
        end else push(S_MEMWR, c, 1, en_end, 1);
      end
      6'b000000: begin
        af = alu_of(fn);
        push(S_EXEC, alu_c(1, 2'b00, af[2:0]), rb(), rb(), 0, af[3]);
        if (!af[3]) begin fault_tail(); return; end
        push(S_ALUWB, wb_c(1, 0), rb(), en_end, 1);
      end
      6'b000100, 6'b000101: begin
        c = alu_c(1, 2'b00, 3'b110); c.pcn = 2'b01; c.br = op == 6'b000100; c.bne = op == 6'b000101;
        push(S_BRANCH, c, rb(), en_end, 1);
      end
      6'b001000: begin
        push(S_ADDIEX, alu_c(1, 2'b10, 3'b010), rb(), rb());
        push(S_ADDIWB, wb_c(0, 0), rb(), en_end, 1);
      end
      6'b000010: begin
        c = '0; c.pcwr = 1; c.pcn = 2'b10;
        push(S_JUMP, c, rb(), en_end, 1);
      end
      default: begin fault_tail(); return; end
    endcase
    if (!en_end) begin
      repeat ($urandom_range(0, 2)) push(S_IDLE, '0, rb(), 0);
      push(S_IDLE, '0, rb(), 1);
    end
  endtask
  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      i_enable = r.en; mem.mem_ready = r.rdy; i_opcode = r.op; i_function = r.fn; i_zero = rb();
      #1;
      check("state", 32'(o_state), 32'(r.st));
      if (r.chk) check("ctrl", 32'(got), 32'(r.c));
      check("fault", 32'(o_fault), 32'(r.st == S_FAULT));
`ifdef MC_PERF_COUNTERS_EN
      check("cycle_cnt", o_cycle_cnt, 32'(m_cyc));
      check("instret_cnt", o_instret_cnt, 32'(m_ret));
`endif
      if (r.st != S_IDLE && r.st != S_FAULT) m_cyc++;
      if (r.ret) m_ret++;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 0; i_enable = 0; mem.mem_ready = 0;
    #1;
    check("rst_state", 32'(o_state), 32'(S_IDLE));
    check("rst_ctrl", 32'(got), 32'(0));
    check("rst_fault", 32'(o_fault), 32'(0));
    @(negedge clk);
    reset = 1; m_cyc = 0; m_ret = 0; dead = 0;
    q.delete();
`ifdef MC_PERF_COUNTERS_EN
    #1;
    check("rst_cycle_cnt", o_cycle_cnt, 32'(0));
    check("rst_instret_cnt", o_instret_cnt, 32'(0));
`endif
  endtask
  initial begin
    mem.mem_ready = 0;
    do_reset();
    push(S_IDLE, '0, rb(), 1);
    for (int n = 0; n < 60; n++)
      gen_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 4)],
                $urandom_range(0, 9) == 0 ? TO - 1 : int'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0 ? TO - 1 : int'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0);
    run_q();
    do_reset(); push(S_IDLE, '0, 0, 1); gen_instr(6'b000010, 6'b0, TO - 1, 0, 1); run_q();
    do_reset(); push(S_IDLE, '0, 0, 1); gen_instr(6'b000000, 6'b100000, TO, 0, 1); run_q();
    do_reset(); push(S_IDLE, '0, 0, 1); gen_instr(6'b100011, 6'b0, 0, TO, 1); run_q();
    do_reset(); push(S_IDLE, '0, 0, 1); gen_instr(6'b101011, 6'b0, 2, TO, 1); run_q();
    do_reset(); push(S_IDLE, '0, 0, 1); gen_instr(6'b111111, 6'b0, 0, 0, 1); run_q();
    do_reset(); push(S_IDLE, '0, 0, 1); gen_instr(6'b000000, 6'b000111, 1, 0, 1); run_q();
    do_reset(); push(S_IDLE, '0, 0, 1); gen_instr(6'b000101, 6'b0, 0, 0, 1);
    gen_instr(6'b000100, 6'b0, 3, 0, 1); gen_instr(6'b000000, 6'b101010, 0, 0, 0); run_q();
    do_reset(); push(S_IDLE, '0, 0, 1);
    cur_op = 6'b100011; cur_fn = 6'b0;
    push(S_FETCH, {7'b0001100, 2'b00, 3'b010, 1'b0, 2'b01, 3'b000} | 18'h20000, 1, 1);
    push(S_DECODE, alu_c(0, 2'b11, 3'b010), 1, 1);
    push(S_MEMADR, alu_c(1, 2'b10, 3'b010), 1, 1);
    push(S_MEMRD, {7'b1010000, 11'b0}, 0, 1);
    run_q();
    @(posedge clk);
    #2;
    check("pre_rst_state", 32'(o_state), 32'(S_MEMRD));
    check("pre_rst_req", 32'(mem.mem_req), 32'(1));
    reset = 0;
    #1;
    check("async_rst_state", 32'(o_state), 32'(S_IDLE));
    check("async_rst_req", 32'(mem.mem_req), 32'(0));
    @(negedge clk);
    reset = 1; i_enable = 1;
    #1;
    check("post_rst_idle", 32'(o_state), 32'(S_IDLE));
    @(negedge clk);
    #1;
    check("post_rst_fetch", 32'(o_state), 32'(S_FETCH));
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
